hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 37 +++
 rtl/hazard_unit_slot.sv | 38 +++
 rtl/hazard_unit.sv | 100 ++++++++++
 tb/tb_hazard_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_defs: shared definitions for the pipeline hazard unit.
//   - forwarding select encodings (FWD_GRF / FWD_W / FWD_M / FWD_E)
//   - slot field widths and the packed slot record
//   - the bubble constant (empty slot)
//   - helpers: saturating t_new decrement and slot/operand match
package hazard_defs;

    localparam int REG_W = 5;
    localparam int T_W   = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_W   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_E   = 2'd3;

    typedef struct packed {
        logic [REG_W-1:0] r_new;
        logic [T_W-1:0]   t_new;
        logic [REG_W-1:0] r_use1;
        logic [REG_W-1:0] r_use2;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    // Counts down toward "result available"; stays at 0 instead of wrapping.
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        logic [T_W-1:0] r;
        r = (t == '0) ? '0 : t - 1'b1;
        return r;
    endfunction

    // Register 0 is hard-wired, so it never produces a hazard or a forward.
    function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r);
        return (r != '0) && (s.r_new == r);
    endfunction

endpackage

// File: rtl/hazard_unit_slot.sv
// hazard_slot: one pipeline-stage record of the hazard tracker.
//   clk    : clock
//   reset  : synchronous active-high clear (wins over everything)
//   bubble : load an empty slot instead of din
//   din    : record from the previous stage (t_new not yet decremented)
//   q      : registered record, t_new already decremented (saturating)
module hazard_slot
    import hazard_defs::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  bubble,
    input  slot_t din,
    output slot_t q
);

    slot_t q_reg;
    slot_t q_next;

    always_comb begin
        q_next       = din;
        q_next.t_new = sat_dec(din.t_new);
        if (bubble) begin
            q_next = BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= BUBBLE;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall and forwarding control for a 5-stage pipeline.
// Tracks the E/M/W instructions as {r_new, t_new, r_use1, r_use2} slots
// and compares them against the D-stage instruction.
//   clk, reset                 : clock, synchronous active-high reset
//   d_r_new / d_t_new          : D-stage destination and cycles until result
//   d_r_use1/2, d_t_use1/2     : D-stage sources (rs / rt) and cycles until needed
//   stall                      : hold PC and D, bubble into E
//   fwd_d_rs/rt                : D operand source (E > M > W)
//   fwd_e_rs/rt                : E operand source (M > W)
//   fwd_m_rt                   : M store-data source (W)
// All outputs are combinational from slot state and D inputs.
module hazard_unit
    import hazard_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] d_r_new,
    input  logic [T_W-1:0]   d_t_new,
    input  logic [REG_W-1:0] d_r_use1,
    input  logic [REG_W-1:0] d_r_use2,
    input  logic [T_W-1:0]   d_t_use1,
    input  logic [T_W-1:0]   d_t_use2,
    output logic             stall,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic [1:0]       fwd_m_rt
);

    slot_t e_din;
    slot_t e_q;
    slot_t m_q;
    slot_t w_q;

    assign e_din = '{r_new: d_r_new, t_new: d_t_new, r_use1: d_r_use1, r_use2: d_r_use2};

    // A stalled D instruction stays in D, so E receives a bubble while M/W keep draining.
    hazard_slot u_slot_e (.clk(clk), .reset(reset), .bubble(stall), .din(e_din), .q(e_q));
    hazard_slot u_slot_m (.clk(clk), .reset(reset), .bubble(1'b0),  .din(e_q),   .q(m_q));
    hazard_slot u_slot_w (.clk(clk), .reset(reset), .bubble(1'b0),  .din(m_q),   .q(w_q));

    // W source fields are never consulted again once the instruction reaches W.
    logic unused_w_fields;
    assign unused_w_fields = &{1'b0, w_q.r_use1, w_q.r_use2};

    logic [1:0][REG_W-1:0] d_use;
    logic [1:0][T_W-1:0]   d_tuse;
    logic [1:0][REG_W-1:0] e_use;

    assign d_use  = {d_r_use2, d_r_use1};
    assign d_tuse = {d_t_use2, d_t_use1};
    assign e_use  = {e_q.r_use2, e_q.r_use1};

    // Operand 0 is the rs slot, operand 1 the rt slot.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic       stall_op;
            logic [1:0] fwd_d_sel;
            logic [1:0] fwd_e_sel;

            // Stall only when a pending producer cannot deliver in time;
            // W always has t_new == 0 so it is left out.
            assign stall_op =
                (slot_match(e_q, d_use[gi]) && (e_q.t_new > d_tuse[gi])) ||
                (slot_match(m_q, d_use[gi]) && (m_q.t_new > d_tuse[gi]));

            always_comb begin
                fwd_d_sel = FWD_GRF;
                if (slot_match(e_q, d_use[gi]) && (e_q.t_new == '0)) begin
                    fwd_d_sel = FWD_E;
                end else if (slot_match(m_q, d_use[gi]) && (m_q.t_new == '0)) begin
                    fwd_d_sel = FWD_M;
                end else if (slot_match(w_q, d_use[gi]) && (w_q.t_new == '0)) begin
                    fwd_d_sel = FWD_W;
                end
            end

            always_comb begin
                fwd_e_sel = FWD_GRF;
                if (slot_match(m_q, e_use[gi]) && (m_q.t_new == '0)) begin
                    fwd_e_sel = FWD_M;
                end else if (slot_match(w_q, e_use[gi]) && (w_q.t_new == '0)) begin
                    fwd_e_sel = FWD_W;
                end
            end
        end
    endgenerate

    assign stall    = g_op[0].stall_op | g_op[1].stall_op;
    assign fwd_d_rs = g_op[0].fwd_d_sel;
    assign fwd_d_rt = g_op[1].fwd_d_sel;
    assign fwd_e_rs = g_op[0].fwd_e_sel;
    assign fwd_e_rt = g_op[1].fwd_e_sel;

    // Store data in M can only be refreshed from the instruction in W.
    assign fwd_m_rt = (slot_match(w_q, m_q.r_use2) && (w_q.t_new == '0)) ? FWD_W : FWD_GRF;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_r_new, d_r_use1, d_r_use2;
    logic [1:0] d_t_new, d_t_use1, d_t_use2;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .d_r_new(d_r_new), .d_t_new(d_t_new),
        .d_r_use1(d_r_use1), .d_r_use2(d_r_use2),
        .d_t_use1(d_t_use1), .d_t_use2(d_t_use2),
        .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
        .fwd_m_rt(fwd_m_rt)
    );

    // ---------------- reference model: stage 1=E, 2=M, 3=W ----------------
    int m_rn [1:3];
    int m_tn [1:3];
    int m_ru1[1:3];
    int m_ru2[1:3];

    function automatic int ref_stall();
        int use_r[2];
        int use_t[2];
        use_r[0] = int'(d_r_use1); use_t[0] = int'(d_t_use1);
        use_r[1] = int'(d_r_use2); use_t[1] = int'(d_t_use2);
        for (int op = 0; op < 2; op++)
            for (int s = 1; s <= 2; s++)
                if (use_r[op] != 0 && m_rn[s] == use_r[op] && m_tn[s] > use_t[op]) return 1;
        return 0;
    endfunction

    // Youngest ready producer among stages lo..3; code is 4 - stage.
    function automatic int ref_src(int r, int lo);
        if (r == 0) return 0;
        for (int s = lo; s <= 3; s++)
            if (m_rn[s] == r && m_tn[s] == 0) return 4 - s;
        return 0;
    endfunction

    task automatic model_advance();
        int st;
        st = ref_stall();
        if (reset) begin
            for (int s = 1; s <= 3; s++) begin
                m_rn[s] = 0; m_tn[s] = 0; m_ru1[s] = 0; m_ru2[s] = 0;
            end
        end else begin
            for (int s = 3; s >= 2; s--) begin
                m_rn[s]  = m_rn[s-1];
                m_tn[s]  = (m_tn[s-1] > 0) ? m_tn[s-1] - 1 : 0;
                m_ru1[s] = m_ru1[s-1];
                m_ru2[s] = m_ru2[s-1];
            end
            if (st != 0) begin
                m_rn[1] = 0; m_tn[1] = 0; m_ru1[1] = 0; m_ru2[1] = 0;
            end else begin
                m_rn[1]  = int'(d_r_new);
                m_tn[1]  = (d_t_new > 0) ? int'(d_t_new) - 1 : 0;
                m_ru1[1] = int'(d_r_use1);
                m_ru2[1] = int'(d_r_use2);
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int rn, input int tn, input int ru1, input int tu1,
                         input int ru2, input int tu2);
        d_r_new  = 5'(rn);  d_t_new  = 2'(tn);
        d_r_use1 = 5'(ru1); d_t_use1 = 2'(tu1);
        d_r_use2 = 5'(ru2); d_t_use2 = 2'(tu2);
    endtask

    // Called at a negative edge: update the model and cross the next rising edge.
    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".stall"},    32'(stall),    32'(ref_stall()));
        chk({tag, ".fwd_d_rs"}, 32'(fwd_d_rs), 32'(ref_src(int'(d_r_use1), 1)));
        chk({tag, ".fwd_d_rt"}, 32'(fwd_d_rt), 32'(ref_src(int'(d_r_use2), 1)));
        chk({tag, ".fwd_e_rs"}, 32'(fwd_e_rs), 32'(ref_src(m_ru1[1], 2)));
        chk({tag, ".fwd_e_rt"}, 32'(fwd_e_rt), 32'(ref_src(m_ru2[1], 2)));
        chk({tag, ".fwd_m_rt"}, 32'(fwd_m_rt), 32'(ref_src(m_ru2[2], 3)));
    endtask

    typedef struct {
        int rn, tn, ru1, tu1, ru2, tu2;
        int st, fdrs, fdrt, fers, fert, fmrt;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // Directed pipeline scenario; each row is one D-stage cycle.
        tbl[0]  = '{8, 3, 0, 3, 0, 3,  0, 0, 0, 0, 0, 0};  // lw $8
        tbl[1]  = '{10,2, 8, 1, 0, 3,  1, 0, 0, 0, 0, 0};  // addu uses $8: stall
        tbl[2]  = '{10,2, 8, 1, 0, 3,  0, 0, 0, 0, 0, 0};  // released
        tbl[3]  = '{0, 0, 0, 3, 0, 3,  0, 0, 0, 1, 0, 0};  // addu in E gets $8 from W
        tbl[4]  = '{9, 2, 0, 3, 0, 3,  0, 0, 0, 0, 0, 0};  // addu $9
        tbl[5]  = '{0, 0, 9, 0, 0, 3,  1, 0, 0, 0, 0, 0};  // beq $9: stall
        tbl[6]  = '{0, 0, 9, 0, 0, 3,  0, 2, 0, 0, 0, 0};  // beq takes $9 from M
        tbl[7]  = '{5, 2, 0, 3, 0, 3,  0, 0, 0, 1, 0, 0};  // ori $5
        tbl[8]  = '{0, 0, 0, 3, 5, 2,  0, 0, 0, 0, 0, 0};  // sw $5 (rt): no stall
        tbl[9]  = '{0, 0, 0, 3, 0, 3,  0, 0, 0, 0, 2, 0};  // sw in E gets $5 from M
        tbl[10] = '{0, 0, 0, 3, 0, 3,  0, 0, 0, 0, 0, 1};  // sw in M gets $5 from W
        tbl[11] = '{0, 3, 0, 3, 0, 3,  0, 0, 0, 0, 0, 0};  // dest $0, t_new 3
        tbl[12] = '{0, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};  // use $0 at t_use 0
        tbl[13] = '{4, 1, 0, 3, 0, 3,  0, 0, 0, 0, 0, 0};  // write $4
        tbl[14] = '{4, 1, 4, 0, 0, 3,  0, 3, 0, 0, 0, 0};  // write $4 again, reads $4 from E
        tbl[15] = '{0, 0, 4, 0, 4, 0,  0, 3, 3, 2, 0, 0};  // E and M both $4: E wins
        tbl[16] = '{0, 0, 0, 3, 0, 3,  0, 0, 0, 2, 2, 0};  // E reads $4: M wins over W
        tbl[17] = '{7, 3, 0, 3, 0, 3,  0, 0, 0, 0, 0, 1};  // lw $7; M store data $4 from W
        tbl[18] = '{0, 0, 7, 0, 0, 3,  1, 0, 0, 0, 0, 0};  // branch on $7: stall on E
        tbl[19] = '{0, 0, 7, 0, 0, 3,  1, 0, 0, 0, 0, 0};  // still stalling on M
        tbl[20] = '{0, 0, 7, 0, 0, 3,  0, 1, 0, 0, 0, 0};  // released, $7 from W

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("rst.stall",    32'(stall),    0);
        chk("rst.fwd_d_rs", 32'(fwd_d_rs), 0);
        chk("rst.fwd_d_rt", 32'(fwd_d_rt), 0);
        chk("rst.fwd_e_rs", 32'(fwd_e_rs), 0);
        chk("rst.fwd_e_rt", 32'(fwd_e_rt), 0);
        chk("rst.fwd_m_rt", 32'(fwd_m_rt), 0);
        drive(0, 0, 3, 0, 3, 0);
        #1;
        chk("rst_read.stall",    32'(stall),    0);
        chk("rst_read.fwd_d_rs", 32'(fwd_d_rs), 0);
        chk("rst_read.fwd_d_rt", 32'(fwd_d_rt), 0);
        $display("[TB] reset state checked");
        drive(0, 0, 0, 0, 0, 0);
        advance();

        // ---- table-driven directed vectors ----
        for (int k = 0; k < 21; k++) begin
            drive(tbl[k].rn, tbl[k].tn, tbl[k].ru1, tbl[k].tu1, tbl[k].ru2, tbl[k].tu2);
            @(negedge clk);
            chk($sformatf("vec%0d.stall", k),    32'(stall),    32'(tbl[k].st));
            chk($sformatf("vec%0d.fwd_d_rs", k), 32'(fwd_d_rs), 32'(tbl[k].fdrs));
            chk($sformatf("vec%0d.fwd_d_rt", k), 32'(fwd_d_rt), 32'(tbl[k].fdrt));
            chk($sformatf("vec%0d.fwd_e_rs", k), 32'(fwd_e_rs), 32'(tbl[k].fers));
            chk($sformatf("vec%0d.fwd_e_rt", k), 32'(fwd_e_rt), 32'(tbl[k].fert));
            chk($sformatf("vec%0d.fwd_m_rt", k), 32'(fwd_m_rt), 32'(tbl[k].fmrt));
            $display("[TB] vec %0d: stall=%0d d=%0d/%0d e=%0d/%0d m=%0d",
                     k, stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt);
            advance();
        end

        // ---- reset in the middle of a load-use stall ----
        do_reset();
        drive(8, 3, 0, 3, 0, 3);
        @(negedge clk);
        advance();
        drive(10, 2, 8, 1, 0, 3);
        @(negedge clk);
        chk("rst_stall.before", 32'(stall), 1);
        reset = 1'b1;
        advance();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_stall.stall",    32'(stall),    0);
        chk("rst_stall.fwd_d_rs", 32'(fwd_d_rs), 0);
        chk("rst_stall.fwd_e_rs", 32'(fwd_e_rs), 0);
        chk("rst_stall.fwd_m_rt", 32'(fwd_m_rt), 0);
        chk("rst_stall.slot_e",   32'(dut.e_q),  0);
        chk("rst_stall.slot_m",   32'(dut.m_q),  0);
        chk("rst_stall.slot_w",   32'(dut.w_q),  0);
        $display("[TB] reset during stall checked");
        advance();

        // ---- randomized traffic against the model ----
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            @(negedge clk);
            check_model($sformatf("rnd%0d", n));
            $display("[TB] rnd %0d: rst=%0d D={%0d,%0d,%0d,%0d} stall=%0d d=%0d/%0d e=%0d/%0d m=%0d",
                     n, reset, d_r_new, d_t_new, d_r_use1, d_r_use2,
                     stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt);
            advance();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
